id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register, directly downstream of the ID-stage destination-register mux.
//  Captures decoded control, register operands, the immediate and the selected destination register on posedge clk.
//  The mux updates on negedge, so its output is stable for a half cycle before capture.
//  Also detects load-use hazards and inserts one bubble per hazard, and handles flush and hold from EX.
// PARAMETERS
//  DATA_W  32  operand/immediate width
//  REG_W   5   register-index width
//  ALUC_W  4   ALU control width
//  CNT_W   16  perf counter width (only with ID_EX_PERF_EN)
// PORTS
//  clk        in   1       pipeline clock, all state updates on posedge
//  rst        in   1       synchronous active-high reset
//  id_valid   in   1       ID holds a real instruction
//  ifid_out   in   32      IF/ID instruction word; rs=[25:21], rt=[20:16]
//  id_uses_rt in   1       instruction reads rt as a source (R-type, sw, beq)
//  mux_id_out in   REG_W   destination register selected in ID (rt or rd)
//  id_wreg    in   1       writes register file
//  id_m2reg   in   1       result comes from memory (load)
//  id_wmem    in   1       writes memory
//  id_aluimm  in   1       ALU B operand is the immediate
//  id_aluc    in   ALUC_W  ALU operation
//  id_qa      in   DATA_W  rs read data
//  id_qb      in   DATA_W  rt read data
//  id_imm     in   DATA_W  extended immediate
//  flush      in   1       squash the ID instruction (branch/jump taken)
//  ex_hold    in   1       EX stalled; keep all ID/EX contents
//  hazard_stall out 1      load-use stall request to PC/IF/ID (combinational)
//  ex_valid,ex_wreg,ex_m2reg,ex_wmem,ex_aluimm  out 1  registered copies
//  ex_aluc    out  ALUC_W  registered ALU op
//  ex_dest    out  REG_W   registered destination register
//  ex_rs,ex_rt out REG_W   registered source indices (for forwarding)
//  ex_qa,ex_qb,ex_imm out DATA_W  registered operands
//  bubble_cnt,flush_cnt out CNT_W  perf counters (ID_EX_PERF_EN only)
// BEHAVIOUR
//  - Reset: every ex_* output is 0. Counters are 0. hazard_stall is 0 because ex_valid=0.
//  - hazard_stall = ex_valid & ex_m2reg & ex_wreg & (ex_dest!=0) & id_valid &
//      (ex_dest==rs | (id_uses_rt & ex_dest==rt)). Purely combinational, no added latency.
//  - Posedge priority (highest first):
//    1. rst
//    2. ex_hold: all registers keep their value, even if flush or hazard_stall is also asserted.
//    3. flush: insert a bubble.
//    4. hazard_stall: insert a bubble. IF/ID and PC hold externally.
//    5. otherwise load all id_* fields. ex_valid<=id_valid.
//  - Bubble: ex_valid, ex_wreg, ex_m2reg and ex_wmem are 0. Other fields don't-care; implementation zeroes them.
//  - id_valid=0 with no flush/hazard: load as normal, but force ex_wreg=ex_wmem=ex_m2reg=0.
//  - Latency: 1 cycle ID->EX. A load followed by a dependent instruction costs exactly one bubble.
//    After the bubble, ex_valid=0, so hazard_stall clears and the dependent instruction advances.
//  - Register $0 never triggers a hazard.
//  - No internal FSM beyond the valid bit. The one-bubble guarantee comes from the bubble clearing ex_m2reg.
//  - Reset asserted mid-stall clears the bubble state; the next cycle after reset loads normally.
// CONFIGURATION
//  ID_EX_PERF_EN defined:
//    - bubble_cnt increments on each hazard bubble; flush_cnt increments on each flush bubble.
//    - Flush takes precedence when both conditions hold.
//    - Neither counter increments while ex_hold.
//    - Both saturate at all-ones and reset to 0.
//  ID_EX_PERF_EN undefined: counter ports are tied to 0 and no counter flops are generated.
// TESTING
//  - Reset: rst=1 for 2 cycles with random inputs -> all ex_* =0, hazard_stall=0.
//  - Pass-through: id_valid=1, dest=5'd8, qa=32'h1234, aluc=4'h2 -> next posedge ex_dest=8, ex_qa=32'h1234, ex_valid=1.
//  - Load-use: lw $t1 (ex_dest=9, ex_m2reg=1), then add with rs=9 -> hazard_stall=1, one bubble (ex_valid=0).
//    The add enters EX next cycle; bubble_cnt=1.
//  - No false hazard: load to $0 followed by rs=0, or rt=9 with id_uses_rt=0 -> hazard_stall=0.
//  - Flush vs hazard vs hold: flush & hazard -> bubble, flush_cnt+1 only.
//    ex_hold=1 with flush=1 for 3 cycles -> outputs frozen, counters unchanged.
//  - Saturation (PERF_EN, CNT_W=4): 20 consecutive hazard bubbles -> bubble_cnt stays 4'hF.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: ID-side decoded fields in, EX-side registered copies and stall/perf status out.
// The ID side (decoder, hazard consumer) uses the master modport; the pipeline register uses slave.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [31:0]       ifid_out;
  logic              id_uses_rt;
  logic [REG_W-1:0]  mux_id_out;
  logic              id_wreg;
  logic              id_m2reg;
  logic              id_wmem;
  logic              id_aluimm;
  logic [ALUC_W-1:0] id_aluc;
  logic [DATA_W-1:0] id_qa;
  logic [DATA_W-1:0] id_qb;
  logic [DATA_W-1:0] id_imm;
  logic              flush;
  logic              ex_hold;

  logic              hazard_stall;
  logic              ex_valid;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic              ex_aluimm;
  logic [ALUC_W-1:0] ex_aluc;
  logic [REG_W-1:0]  ex_dest;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [DATA_W-1:0] ex_qa;
  logic [DATA_W-1:0] ex_qb;
  logic [DATA_W-1:0] ex_imm;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, ifid_out, id_uses_rt, mux_id_out, id_wreg, id_m2reg, id_wmem,
           id_aluimm, id_aluc, id_qa, id_qb, id_imm, flush, ex_hold,
    input  hazard_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc,
           ex_dest, ex_rs, ex_rt, ex_qa, ex_qb, ex_imm, bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, ifid_out, id_uses_rt, mux_id_out, id_wreg, id_m2reg, id_wmem,
           id_aluimm, id_aluc, id_qa, id_qb, id_imm, flush, ex_hold,
    output hazard_stall, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc,
           ex_dest, ex_rs, ex_rt, ex_qa, ex_qb, ex_imm, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and EX hold.
// Optional perf counters (bubble_cnt, flush_cnt) are built only when ID_EX_PERF_EN is defined.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] imm;
  } stage_t;

  stage_t           ex_q;
  stage_t           ex_d;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             hazard;

  assign id_rs = REG_W'(bus.ifid_out[25:21]);
  assign id_rt = REG_W'(bus.ifid_out[20:16]);

  // A bubble clears ex_m2reg, so a single load can never stall the same consumer twice.
  assign hazard = ex_q.valid & ex_q.m2reg & ex_q.wreg & (ex_q.dest != '0) & bus.id_valid &
                  ((ex_q.dest == id_rs) | (bus.id_uses_rt & (ex_q.dest == id_rt)));

  // NOTE: every field of ex_d is assigned before any branch so no latch is inferred.
  always_comb begin
    ex_d = ex_q;
    if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (bus.flush || hazard) begin
      ex_d = '0;
    end else begin
      ex_d.valid  = bus.id_valid;
      ex_d.wreg   = bus.id_valid & bus.id_wreg;
      ex_d.m2reg  = bus.id_valid & bus.id_m2reg;
      ex_d.wmem   = bus.id_valid & bus.id_wmem;
      ex_d.aluimm = bus.id_aluimm;
      ex_d.aluc   = bus.id_aluc;
      ex_d.dest   = bus.mux_id_out;
      ex_d.rs     = id_rs;
      ex_d.rt     = id_rt;
      ex_d.qa     = bus.id_qa;
      ex_d.qb     = bus.id_qb;
      ex_d.imm    = bus.id_imm;
    end
  end

  // NOTE: reset is synchronous and active-high; state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_wreg      = ex_q.wreg;
  assign bus.ex_m2reg     = ex_q.m2reg;
  assign bus.ex_wmem      = ex_q.wmem;
  assign bus.ex_aluimm    = ex_q.aluimm;
  assign bus.ex_aluc      = ex_q.aluc;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_qa        = ex_q.qa;
  assign bus.ex_qb        = ex_q.qb;
  assign bus.ex_imm       = ex_q.imm;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;
  logic             count_flush;
  logic             count_bubble;

  // Flush wins over a simultaneous hazard; nothing is counted while EX holds.
  assign count_flush  = ~bus.ex_hold & bus.flush;
  assign count_bubble = ~bus.ex_hold & ~bus.flush & hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (count_bubble && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
      if (count_flush && (flush_q != '1))   flush_q  <= flush_q + 1'b1;
    end
  end

  assign bus.bubble_cnt = bubble_q;
  assign bus.flush_cnt  = flush_q;
`else
  assign bus.bubble_cnt = '0;
  assign bus.flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, pass-through, load-use bubbles, flush/hold, saturation.
// Counter expectations collapse to zero when ID_EX_PERF_EN is not defined.
module tb_id_ex_stage_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ALUC_W = 4;
  localparam int CNT_W  = 4;
`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [CNT_W-1:0] exp_b = '0;
  logic [CNT_W-1:0] exp_f = '0;

  id_ex_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ir(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 16'h0000};
  endfunction

  task automatic drive(input logic v, input logic [31:0] word, input logic urt,
                       input logic [4:0] dest, input logic w, input logic m, input logic wm,
                       input logic ai, input logic [3:0] aluc,
                       input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm);
    bus.id_valid   = v;
    bus.ifid_out   = word;
    bus.id_uses_rt = urt;
    bus.mux_id_out = dest;
    bus.id_wreg    = w;
    bus.id_m2reg   = m;
    bus.id_wmem    = wm;
    bus.id_aluimm  = ai;
    bus.id_aluc    = aluc;
    bus.id_qa      = qa;
    bus.id_qb      = qb;
    bus.id_imm     = imm;
  endtask

  task automatic load9();
    drive(1'b1, ir(5'd1, 5'd0), 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 32'h4);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_bcnt"}, 64'(bus.bubble_cnt), PERF ? 64'(exp_b) : 64'(0));
    check({tag, "_fcnt"}, 64'(bus.flush_cnt),  PERF ? 64'(exp_f) : 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    drive(1'($urandom), $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom);
    bus.flush   = 1'($urandom);
    bus.ex_hold = 1'($urandom);
    tick(); tick();
    check("rst_valid", 64'(bus.ex_valid), 64'(0));
    check("rst_ctrl", 64'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm}), 64'(0));
    check("rst_idx", 64'({bus.ex_aluc, bus.ex_dest, bus.ex_rs, bus.ex_rt}), 64'(0));
    check("rst_data", 64'(bus.ex_qa | bus.ex_qb | bus.ex_imm), 64'(0));
    check("rst_haz", 64'(bus.hazard_stall), 64'(0));
    check_cnt("rst");
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;

    // Pass-through
    drive(1'b1, ir(5'd3, 5'd4), 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2,
          32'h1234, 32'h5678, 32'h9abc);
    tick();
    check("pt_valid", 64'(bus.ex_valid), 64'(1));
    check("pt_dest", 64'(bus.ex_dest), 64'(8));
    check("pt_qa", 64'(bus.ex_qa), 64'h1234);
    check("pt_qb_imm", 64'({bus.ex_qb, bus.ex_imm}), 64'h0000_5678_0000_9abc);
    check("pt_aluc", 64'(bus.ex_aluc), 64'h2);
    check("pt_rs_rt", 64'({bus.ex_rs, bus.ex_rt}), 64'({5'd3, 5'd4}));
    check("pt_wreg", 64'(bus.ex_wreg), 64'(1));

    // Load-use: one bubble, then the dependent add enters EX
    load9();
    tick();
    check("ld_m2reg", 64'(bus.ex_m2reg), 64'(1));
    drive(1'b1, ir(5'd9, 5'd10), 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1,
          32'h7, 32'h8, 32'h0);
    #1;
    check("lu_haz", 64'(bus.hazard_stall), 64'(1));
    tick();
    exp_b = exp_b + 1'b1;
    check("lu_bubble_valid", 64'(bus.ex_valid), 64'(0));
    check("lu_bubble_ctrl", 64'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), 64'(0));
    check("lu_bubble_dest", 64'(bus.ex_dest), 64'(0));
    check("lu_haz_clear", 64'(bus.hazard_stall), 64'(0));
    check_cnt("lu");
    tick();
    check("lu_adv_valid", 64'(bus.ex_valid), 64'(1));
    check("lu_adv_dest", 64'(bus.ex_dest), 64'(11));
    check("lu_adv_rs", 64'(bus.ex_rs), 64'(9));

    // Load to $0 never stalls
    drive(1'b1, ir(5'd1, 5'd0), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b1, ir(5'd0, 5'd0), 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'h0, 32'h0, 32'h0);
    #1;
    check("r0_haz", 64'(bus.hazard_stall), 64'(0));

    // rt only matters when the instruction reads it
    load9();
    tick();
    drive(1'b1, ir(5'd1, 5'd9), 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 32'h0, 32'h0, 32'h0);
    #1;
    check("rt_unused_haz", 64'(bus.hazard_stall), 64'(0));
    bus.id_uses_rt = 1'b1;
    #1;
    check("rt_used_haz", 64'(bus.hazard_stall), 64'(1));
    bus.id_uses_rt = 1'b0;
    tick();
    check("rt_adv", 64'({bus.ex_valid, bus.ex_rt}), 64'({1'b1, 5'd9}));

    // Invalid ID slot loads data but no side effects
    drive(1'b0, ir(5'd2, 5'd3), 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3,
          32'hAAAA, 32'hBBBB, 32'hCCCC);
    tick();
    check("inv_ctrl", 64'({bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), 64'(0));
    check("inv_data", 64'({bus.ex_dest, bus.ex_qa}), 64'({5'd9, 32'hAAAA}));
    drive(1'b1, ir(5'd9, 5'd0), 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'h0, 32'h0, 32'h0);
    #1;
    check("inv_haz", 64'(bus.hazard_stall), 64'(0));

    // Flush and hazard together: bubble, counted as a flush only
    load9();
    tick();
    drive(1'b1, ir(5'd9, 5'd0), 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'h0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    #1;
    check("fh_haz", 64'(bus.hazard_stall), 64'(1));
    tick();
    exp_f = exp_f + 1'b1;
    check("fh_valid", 64'(bus.ex_valid), 64'(0));
    check_cnt("fh");
    bus.flush = 1'b0;

    // Hold with flush and hazard pending: everything frozen
    drive(1'b1, ir(5'd1, 5'd0), 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'h6,
          32'h55, 32'h66, 32'h77);
    tick();
    drive(1'b1, ir(5'd5, 5'd0), 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1,
          32'h1, 32'h2, 32'h3);
    bus.ex_hold = 1'b1;
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ctrl", 64'({bus.ex_valid, bus.ex_wreg, bus.ex_m2reg}), 64'(3'b111));
      check("hold_data", 64'({bus.ex_dest, bus.ex_aluc, bus.ex_qa}), 64'({5'd5, 4'h6, 32'h55}));
    end
    check_cnt("hold");
    bus.ex_hold = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("hold_rel_haz", 64'(bus.hazard_stall), 64'(1));
    tick();
    exp_b = exp_b + 1'b1;
    check("hold_rel_bubble", 64'(bus.ex_valid), 64'(0));
    tick();
    check("hold_rel_adv", 64'({bus.ex_valid, bus.ex_dest}), 64'({1'b1, 5'd14}));
    check_cnt("hold_rel");

    // Twenty load-use bubbles saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      load9();
      tick();
      drive(1'b1, ir(5'd9, 5'd0), 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1,
            32'h0, 32'h0, 32'h0);
      tick();
      if (exp_b != '1) exp_b = exp_b + 1'b1;
      check("sat_bubble", 64'(bus.ex_valid), 64'(0));
    end
    check_cnt("sat");

    // Reset in the middle of a stall
    load9();
    tick();
    drive(1'b1, ir(5'd9, 5'd0), 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1,
          32'h0, 32'h0, 32'h0);
    #1;
    check("mid_haz", 64'(bus.hazard_stall), 64'(1));
    rst = 1'b1;
    tick();
    exp_b = '0;
    exp_f = '0;
    check("mid_rst", 64'({bus.ex_valid, bus.ex_m2reg, bus.ex_dest}), 64'(0));
    check_cnt("mid_rst");
    rst = 1'b0;
    #1;
    check("mid_haz_clear", 64'(bus.hazard_stall), 64'(0));
    tick();
    check("mid_adv", 64'({bus.ex_valid, bus.ex_dest, bus.ex_rs}), 64'({1'b1, 5'd15, 5'd9}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
